// File: rtl/coin_credit_if.sv
// Coin/credit bus between the board coin inputs, the credit accumulator and vending control.
interface coin_credit_if #(
  parameter int unsigned NUM_COINS = 4,
  parameter int unsigned VALUE_W   = 12
);
  logic [NUM_COINS-1:0] coin_in;
  logic [VALUE_W-1:0]   price;
  logic                 buy;
  logic                 cancel;
  logic [VALUE_W-1:0]   credit;
  logic                 vend;
  logic                 change_valid;
  logic [VALUE_W-1:0]   change;
  logic                 coin_reject;
  logic                 busy;

  modport master (output coin_in, price, buy, cancel,
                  input  credit, vend, change_valid, change, coin_reject, busy);
  modport slave  (input  coin_in, price, buy, cancel,
                  output credit, vend, change_valid, change, coin_reject, busy);
endinterface

// File: rtl/coin_credit_accumulator.sv
// Coin credit accumulator: synchronised coin inputs, overflow-protected credit, buy with change, cancel with refund.
// Optional per-coin debounce filter enabled by defining COIN_DEBOUNCE_EN.
module coin_credit_accumulator #(
  parameter int unsigned                  NUM_COINS       = 4,
  parameter int unsigned                  VALUE_W         = 12,
  parameter logic [NUM_COINS*VALUE_W-1:0] COIN_VALUES     = {12'd1000, 12'd500, 12'd100, 12'd50},
  parameter int unsigned                  MAX_CREDIT      = 4000,
  parameter int unsigned                  DEBOUNCE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  coin_credit_if.slave bus
);

  localparam int unsigned SUM_W = VALUE_W + 4;

  typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_REFUND} state_t;

  if (NUM_COINS < 1 || NUM_COINS > 8 || DEBOUNCE_CYCLES < 1 ||
      64'(MAX_CREDIT) >= (64'd1 << VALUE_W)) begin : g_bad_cfg
    $error("coin_credit_accumulator: illegal parameter set");
  end

  state_t               r_state, w_state_n;
  logic [NUM_COINS-1:0] r_sync1, r_sync2, r_level_q;
  logic [NUM_COINS-1:0] w_level, w_coin_evt;
  logic [VALUE_W-1:0]   r_credit, w_credit_n;
  logic [VALUE_W-1:0]   r_change, w_change_n;
  logic                 r_vend, w_vend_n;
  logic                 r_change_valid, w_change_valid_n;
  logic                 r_coin_reject, w_coin_reject_n;
  logic                 r_busy, w_busy_n;
  logic                 w_take_coins;
  logic [SUM_W-1:0]     w_sum, w_total;

  // Two-flop synchroniser on the raw buttons
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.coin_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef COIN_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CNT_W-1:0]     r_db_cnt [NUM_COINS];
  logic [NUM_COINS-1:0] r_filt;

  // Filtered level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_filt <= '0;
      for (int i = 0; i < NUM_COINS; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_COINS; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_filt[i]   <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign w_level = r_filt;
`else
  assign w_level = r_sync2;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_level_q <= '0;
    else        r_level_q <= w_level;
  end

  assign w_coin_evt = w_level & ~r_level_q;

  // Sum of all coins arriving this cycle, wide enough to never wrap
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_COINS; i++) begin
      if (w_coin_evt[i]) w_sum = w_sum + SUM_W'(COIN_VALUES[i*VALUE_W +: VALUE_W]);
    end
  end

  assign w_total = SUM_W'(r_credit) + w_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_credit       <= '0;
      r_change       <= '0;
      r_vend         <= 1'b0;
      r_change_valid <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_n;
      r_credit       <= w_credit_n;
      r_change       <= w_change_n;
      r_vend         <= w_vend_n;
      r_change_valid <= w_change_valid_n;
      r_coin_reject  <= w_coin_reject_n;
      r_busy         <= w_busy_n;
    end
  end

  // Next state and next registered outputs; buy/cancel use the pre-coin credit
  always_comb begin
    w_state_n        = r_state;
    w_credit_n       = r_credit;
    w_change_n       = r_change;
    w_vend_n         = 1'b0;
    w_change_valid_n = 1'b0;
    w_coin_reject_n  = 1'b0;
    w_take_coins     = 1'b1;

    case (r_state)
      S_IDLE: begin
        w_take_coins = 1'b1;
      end
      S_CREDIT: begin
        if (bus.cancel) begin
          w_state_n        = S_REFUND;
          w_change_valid_n = 1'b1;
          w_change_n       = r_credit;
          w_take_coins     = 1'b0;
        end else if (bus.buy && (r_credit >= bus.price)) begin
          w_state_n        = S_VEND;
          w_vend_n         = 1'b1;
          w_change_valid_n = 1'b1;
          w_change_n       = r_credit - bus.price;
          w_take_coins     = 1'b0;
        end
      end
      S_VEND, S_REFUND: begin
        w_state_n    = S_IDLE;
        w_credit_n   = '0;
        w_take_coins = 1'b0;
      end
      default: begin
        w_state_n  = S_IDLE;
        w_credit_n = '0;
      end
    endcase

    if (|w_coin_evt) begin
      if (w_take_coins && (w_total <= SUM_W'(MAX_CREDIT))) begin
        w_credit_n = VALUE_W'(w_total);
        if (w_total != '0) w_state_n = S_CREDIT;
      end else begin
        w_coin_reject_n = 1'b1;
      end
    end

    w_busy_n = (w_state_n == S_VEND) || (w_state_n == S_REFUND);
  end

  assign bus.credit       = r_credit;
  assign bus.change       = r_change;
  assign bus.vend         = r_vend;
  assign bus.change_valid = r_change_valid;
  assign bus.coin_reject  = r_coin_reject;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Directed bench for coin_credit_accumulator: credit build-up, buy/change, cancel/refund, overflow and reset.
module tb_coin_credit_accumulator;

  localparam int unsigned NUM_COINS = 4;
  localparam int unsigned VALUE_W   = 12;
`ifdef COIN_DEBOUNCE_EN
  localparam int LAT = 3 + 16;
`else
  localparam int LAT = 3;
`endif
  localparam int HOLD = LAT + 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_vend   = 0;
  int n_cv     = 0;
  int n_rej    = 0;
  int snap_v, snap_c, snap_r;

  coin_credit_if #(.NUM_COINS(NUM_COINS), .VALUE_W(VALUE_W)) bus ();

  coin_credit_accumulator #(
    .NUM_COINS      (NUM_COINS),
    .VALUE_W        (VALUE_W),
    .COIN_VALUES    ({12'd1000, 12'd500, 12'd100, 12'd50}),
    .MAX_CREDIT     (4000),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  always @(negedge clk) begin
    if (bus.vend)         n_vend++;
    if (bus.change_valid) n_cv++;
    if (bus.coin_reject)  n_rej++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drop_coin(input logic [NUM_COINS-1:0] m, input int hold);
    @(negedge clk);
    bus.coin_in = m;
    repeat (hold) @(negedge clk);
    bus.coin_in = '0;
    repeat (HOLD + 1) @(negedge clk);
  endtask

  initial begin
    bus.coin_in = '0;
    bus.price   = '0;
    bus.buy     = 1'b0;
    bus.cancel  = 1'b0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_credit", 32'(bus.credit), 0);
    check_eq("rst_change", 32'(bus.change), 0);
    check_eq("rst_vend", 32'(bus.vend), 0);
    check_eq("rst_cv", 32'(bus.change_valid), 0);
    check_eq("rst_reject", 32'(bus.coin_reject), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // First coin: latency and value
    bus.coin_in = 4'b0010;
    repeat (LAT - 1) @(negedge clk);
    check_eq("coin100_early", 32'(bus.credit), 0);
    @(negedge clk);
    check_eq("coin100", 32'(bus.credit), 100);
    repeat (2) @(negedge clk);
    bus.coin_in = '0;
    repeat (HOLD + 1) @(negedge clk);
    drop_coin(4'b0100, HOLD);
    check_eq("coin500_total", 32'(bus.credit), 600);
    check_eq("no_reject_yet", 32'(n_rej), 0);
    check_eq("credit_not_busy", 32'(bus.busy), 0);

    // Buy 550 from 600
    snap_v = n_vend; snap_c = n_cv;
    bus.price = 12'd550;
    bus.buy   = 1'b1;
    @(negedge clk);
    check_eq("buy_vend", 32'(bus.vend), 1);
    check_eq("buy_cv", 32'(bus.change_valid), 1);
    check_eq("buy_change", 32'(bus.change), 50);
    check_eq("buy_busy", 32'(bus.busy), 1);
    bus.buy = 1'b0;
    @(negedge clk);
    check_eq("buy_vend_off", 32'(bus.vend), 0);
    check_eq("buy_credit0", 32'(bus.credit), 0);
    check_eq("buy_change_held", 32'(bus.change), 50);
    repeat (2) @(negedge clk);
    check_eq("buy_vend_pulses", 32'(n_vend - snap_v), 1);
    check_eq("buy_cv_pulses", 32'(n_cv - snap_c), 1);

    // Overflow protection around MAX_CREDIT
    drop_coin(4'b1000, HOLD);
    drop_coin(4'b1000, HOLD);
    drop_coin(4'b1000, HOLD);
    drop_coin(4'b0100, HOLD);
    check_eq("build_3500", 32'(bus.credit), 3500);
    snap_r = n_rej;
    drop_coin(4'b1000, HOLD);
    check_eq("ovf_credit", 32'(bus.credit), 3500);
    check_eq("ovf_reject", 32'(n_rej - snap_r), 1);
    drop_coin(4'b0100, HOLD);
    check_eq("max_credit", 32'(bus.credit), 4000);
    check_eq("max_no_reject", 32'(n_rej - snap_r), 1);
    bus.cancel = 1'b1;
    @(negedge clk);
    check_eq("refund_cv", 32'(bus.change_valid), 1);
    check_eq("refund_change", 32'(bus.change), 4000);
    check_eq("refund_vend", 32'(bus.vend), 0);
    bus.cancel = 1'b0;
    @(negedge clk);
    check_eq("refund_credit0", 32'(bus.credit), 0);

    // Insufficient credit, then cancel beats buy
    drop_coin(4'b0010, HOLD);
    snap_v = n_vend;
    bus.price = 12'd500;
    bus.buy   = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("short_credit", 32'(bus.credit), 100);
    check_eq("short_busy", 32'(bus.busy), 0);
    check_eq("short_no_vend", 32'(n_vend - snap_v), 0);
    bus.cancel = 1'b1;
    @(negedge clk);
    check_eq("cancel_prio_cv", 32'(bus.change_valid), 1);
    check_eq("cancel_prio_vend", 32'(bus.vend), 0);
    check_eq("cancel_prio_change", 32'(bus.change), 100);
    bus.cancel = 1'b0;
    bus.buy    = 1'b0;
    @(negedge clk);
    check_eq("cancel_credit0", 32'(bus.credit), 0);

    // Two coins in one cycle, held high
    snap_r = n_rej;
    bus.coin_in = 4'b0011;
    repeat (LAT) @(negedge clk);
    check_eq("dual_coin", 32'(bus.credit), 150);
    repeat (20) @(negedge clk);
    check_eq("dual_hold", 32'(bus.credit), 150);
    check_eq("dual_no_reject", 32'(n_rej - snap_r), 0);
    bus.coin_in = '0;
    repeat (HOLD + 1) @(negedge clk);

    // Coin landing in the same cycle as an accepted buy is refused
    bus.price   = 12'd100;
    bus.coin_in = 4'b0001;
    repeat (LAT - 1) @(negedge clk);
    bus.buy = 1'b1;
    @(negedge clk);
    check_eq("race_vend", 32'(bus.vend), 1);
    check_eq("race_change", 32'(bus.change), 50);
    check_eq("race_reject", 32'(bus.coin_reject), 1);
    bus.buy = 1'b0;
    @(negedge clk);
    check_eq("race_credit0", 32'(bus.credit), 0);
    bus.coin_in = '0;
    repeat (HOLD + 1) @(negedge clk);

    // Reset in the middle of a VEND cycle, price 0
    drop_coin(4'b0001, HOLD);
    bus.price = 12'd0;
    bus.buy   = 1'b1;
    @(negedge clk);
    check_eq("p0_vend", 32'(bus.vend), 1);
    check_eq("p0_change", 32'(bus.change), 50);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_vend", 32'(bus.vend), 0);
    check_eq("mid_rst_cv", 32'(bus.change_valid), 0);
    check_eq("mid_rst_credit", 32'(bus.credit), 0);
    check_eq("mid_rst_busy", 32'(bus.busy), 0);
    bus.buy = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("post_rst_credit", 32'(bus.credit), 0);

`ifdef COIN_DEBOUNCE_EN
    // Short glitch must be filtered out
    snap_r = n_rej;
    drop_coin(4'b1000, 5);
    repeat (10) @(negedge clk);
    check_eq("glitch_credit", 32'(bus.credit), 0);
    check_eq("glitch_reject", 32'(n_rej - snap_r), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_credit_accumulator.md
Name: coin_credit_accumulator

Overview:
Parametrised, fully synchronous successor to the two-button coin counter. Accepts NUM_COINS coin-pulse inputs of configurable denomination, accumulates credit with overflow protection, and handles purchase against a price input with change calculation, or cancellation with refund. Sits between the board button/switch inputs and the vending control/display logic.

Parameters:
NUM_COINS, 4, number of coin inputs (1..8)
VALUE_W, 12, width of credit/price/change values
COIN_VALUES, {12'd1000,12'd500,12'd100,12'd50}, packed NUM_COINS*VALUE_W denominations; coin i = COIN_VALUES[i*VALUE_W +: VALUE_W]
MAX_CREDIT, 4000, credit ceiling (must be < 2**VALUE_W)
DEBOUNCE_CYCLES, 16, stable cycles required when debounce is compiled in

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
coin_in  input  NUM_COINS  raw coin buttons, asynchronous, active-high
price  input  VALUE_W  product price, sampled on accepted buy
buy  input  1  purchase request, synchronous level, acted on when high in CREDIT
cancel  input  1  refund request, synchronous level
credit  output  VALUE_W  current accumulated credit
vend  output  1  one-cycle pulse, purchase accepted
change_valid  output  1  one-cycle pulse, change/refund amount valid
change  output  VALUE_W  change or refund amount, held until next change_valid
coin_reject  output  1  one-cycle pulse, a coin was refused
busy  output  1  high in VEND or REFUND state

Behaviour:
- Reset (reset=0, async): credit=0, change=0, vend=0, change_valid=0, coin_reject=0, busy=0, state=IDLE, all synchroniser/edge flops=0.
- Each coin_in bit: 2-flop synchroniser + edge register; coin event = rising edge of synchronised signal. Credit updates on the 3rd rising clk edge after coin_in rises (set-up met).
- Simultaneous coin events in one cycle: all summed. Sum computed VALUE_W+4 bits wide; if credit+sum > MAX_CREDIT, ALL coins of that cycle rejected, credit unchanged, coin_reject pulses 1 cycle.
- credit == MAX_CREDIT exactly is legal.
- FSM states: IDLE (credit=0), CREDIT (credit>0), VEND, REFUND.
- IDLE -> CREDIT on first accepted coin. Buy/cancel in IDLE ignored.
- CREDIT: cancel has priority over buy. cancel=1 -> REFUND. buy=1 and credit>=price -> VEND. buy=1 and credit<price -> ignored, stay CREDIT.
- VEND (1 cycle): vend=1, change_valid=1, change=credit-price (price latched at transition), credit->0 on exit, next state IDLE. price=0 legal: change=credit.
- REFUND (1 cycle): change_valid=1, change=credit, credit->0, next state IDLE; vend stays 0.
- Coin events arriving while busy=1 rejected (coin_reject pulse, no credit).
- Coin event in same cycle as accepted buy/cancel: coin rejected; buy/cancel proceeds on pre-coin credit.
- Outputs vend/change_valid/coin_reject registered; never high more than 1 cycle per event.
- Holding a coin button high produces exactly one event; re-arm needs a low.
- Reset mid-VEND/REFUND: outputs cleared immediately, no pulse completes.

Optional Feature:
Macro COIN_DEBOUNCE_EN. Defined: after the synchroniser, each coin bit passes a per-channel counter; filtered level changes only after DEBOUNCE_CYCLES consecutive equal samples; edge detect on filtered level, latency becomes 3+DEBOUNCE_CYCLES cycles; glitches shorter than DEBOUNCE_CYCLES produce no event. Undefined: no counters, 3-cycle latency, every synchronised rising edge counts.

Test Plan:
- Reset release, pulse coin_in[1] (100) then coin_in[2] (500) -> credit 100 then 600, state CREDIT, coin_reject=0.
- credit=600, price=550, buy=1 -> vend and change_valid pulse 1 cycle, change=50, credit=0, state IDLE.
- credit=3500, pulse coin_in[3] (1000) -> coin_reject pulse, credit stays 3500; pulse coin_in[2] (500) -> credit 4000.
- credit=100, price=500, buy=1 -> no vend, credit 100; then cancel=1 with buy=1 -> change_valid, change=100, vend=0.
- coin_in[0] and coin_in[1] rise same cycle from credit 0 -> credit 150 in one update; hold both high 20 cycles -> no further change.
- Assert reset during VEND cycle -> vend/change_valid low, credit=0 immediately; with COIN_DEBOUNCE_EN, 5-cycle coin glitch -> no credit change.
